// File: rtl/regfile_2r1w.sv
// regfile_2r1w: register file for the operand-fetch stage.
// Two registered read ports and one write port with same-cycle write-to-read
// bypass. After reset a sweep clears one register per cycle; ready rises on
// the edge that clears the last register.
module regfile_2r1w #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 16,
    parameter int ADDR_W = 4,
    parameter int RA_IDX = NREGS - 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       inst,
    input  logic              is_st,
    input  logic              is_ret,
    input  logic              stall,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] op1,
    output logic [DATA_W-1:0] op2,
    output logic              ready
);

    localparam logic [0:0] S_CLEAR = 1'b0;
    localparam logic [0:0] S_RUN   = 1'b1;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);
    localparam logic [ADDR_W-1:0] RA_ADDR  = ADDR_W'(RA_IDX);

    logic [0:0]        state;
    logic [ADDR_W-1:0] cnt;
    logic [DATA_W-1:0] regs [NREGS];

    // Instruction fields, truncated to the register index width.
    logic [ADDR_W-1:0] rd, rs1, rs2;
    logic [ADDR_W-1:0] a1, a2;
    logic [DATA_W-1:0] rd1, rd2;

    // Only the register fields of inst matter here; the rest of the word is
    // folded into a sink so that the whole bus counts as consumed.
    logic unused_inst;
    assign unused_inst = ^inst;

    assign rd  = inst[22 +: ADDR_W];
    assign rs1 = inst[18 +: ADDR_W];
    assign rs2 = inst[14 +: ADDR_W];

    // Port steering: returns read the link register, stores read rd as data.
    assign a1 = is_ret ? RA_ADDR : rs1;
    assign a2 = is_st  ? rd      : rs2;

    // Read data with bypass so a write in the same cycle is visible.
    assign rd1 = (we && (wr_addr == a1)) ? wr_data : regs[a1];
    assign rd2 = (we && (wr_addr == a2)) ? wr_data : regs[a2];

    // Control FSM: sweep counter runs to the last index then saturates in RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_CLEAR;
            cnt   <= '0;
            ready <= 1'b0;
        end else if (state == S_CLEAR) begin
            if (cnt == LAST_IDX) begin
                state <= S_RUN;
                ready <= 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Register array: clear sweep has priority; write-back only in RUN.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == S_CLEAR) begin
                regs[cnt] <= '0;
            end else if (we) begin
                regs[wr_addr] <= wr_data;
            end
        end
    end

    // Operand registers: zero while clearing, held on stall, else fetched.
    always_ff @(posedge clk) begin
        if (rst || (state == S_CLEAR)) begin
            op1 <= '0;
            op2 <= '0;
        end else if (!stall) begin
            op1 <= rd1;
            op2 <= rd2;
        end
    end

endmodule

// File: tb/tb_regfile_2r1w.sv
// tb_regfile_2r1w: runs a 16-entry and an 8-entry register file side by side
// on shared stimulus, each against its own behavioural model.
module tb_regfile_2r1w;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] inst = '0;
    logic        is_st = 1'b0;
    logic        is_ret = 1'b0;
    logic        stall = 1'b0;
    logic        we = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;

    logic [31:0] op1_a, op2_a, op1_b, op2_b;
    logic        rdy_a, rdy_b;

    int n_chk  = 0;
    int n_fail = 0;

    // Model state, index 0 = 16 registers, index 1 = 8 registers.
    logic [31:0] mreg [2][16];
    logic [31:0] mop1 [2];
    logic [31:0] mop2 [2];
    logic        mrdy [2];
    int          msince [2];

    always #5 clk = ~clk;

    regfile_2r1w #(.DATA_W(32), .NREGS(16), .ADDR_W(4)) dut16 (
        .clk(clk), .rst(rst), .inst(inst), .is_st(is_st), .is_ret(is_ret),
        .stall(stall), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
        .op1(op1_a), .op2(op2_a), .ready(rdy_a)
    );

    regfile_2r1w #(.DATA_W(32), .NREGS(8), .ADDR_W(3)) dut8 (
        .clk(clk), .rst(rst), .inst(inst), .is_st(is_st), .is_ret(is_ret),
        .stall(stall), .we(we), .wr_addr(wr_addr[2:0]), .wr_data(wr_data),
        .op1(op1_b), .op2(op2_b), .ready(rdy_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock of architectural behaviour for a file of nr registers.
    task automatic model(input int k, input int nr);
        int m, a1, a2, wa;
        m  = nr - 1;
        a1 = is_ret ? m : (int'(inst[21:18]) & m);
        a2 = is_st ? (int'(inst[25:22]) & m) : (int'(inst[17:14]) & m);
        wa = int'(wr_addr) & m;
        if (rst) begin
            msince[k] = 0;
            mrdy[k]   = 1'b0;
            mop1[k]   = '0;
            mop2[k]   = '0;
        end else if (!mrdy[k]) begin
            mreg[k][msince[k]] = '0;
            msince[k]++;
            mrdy[k] = (msince[k] == nr);
            mop1[k] = '0;
            mop2[k] = '0;
        end else begin
            if (!stall) begin
                mop1[k] = (we && wa == a1) ? wr_data : mreg[k][a1];
                mop2[k] = (we && wa == a2) ? wr_data : mreg[k][a2];
            end
            if (we) mreg[k][wa] = wr_data;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model(0, 16);
        model(1, 8);
        chk("op1_r16", op1_a, mop1[0]);
        chk("op2_r16", op2_a, mop2[0]);
        chk("rdy_r16", {31'b0, rdy_a}, {31'b0, mrdy[0]});
        chk("op1_r8", op1_b, mop1[1]);
        chk("op2_r8", op2_b, mop2[1]);
        chk("rdy_r8", {31'b0, rdy_b}, {31'b0, mrdy[1]});
    endtask

    function automatic logic [31:0] mk(input int rd_i, input int rs1_i, input int rs2_i);
        logic [31:0] w;
        w = '0;
        w[25:22] = 4'(rd_i);
        w[21:18] = 4'(rs1_i);
        w[17:14] = 4'(rs2_i);
        return w;
    endfunction

    task automatic wr(input int a, input logic [31:0] d);
        we = 1'b1;
        wr_addr = 4'(a);
        wr_data = d;
        step();
        we = 1'b0;
    endtask

    // Reset, then count edges until both files report ready (bounded).
    task automatic clear_check(input string tag);
        int e16, e8;
        e16 = 0;
        e8  = 0;
        rst = 1'b1;
        step();
        chk({tag, "_rst_op1"}, op1_a, 32'h0);
        chk({tag, "_rst_rdy"}, {31'b0, rdy_a}, 32'h0);
        rst = 1'b0;
        for (int e = 1; e <= 40; e++) begin
            we = 1'b1;
            wr_addr = 4'd3;
            wr_data = 32'hDEAD;
            step();
            if (rdy_b === 1'b1 && e8 == 0) e8 = e;
            if (rdy_a === 1'b1 && e16 == 0) e16 = e;
            if (e16 != 0) break;
            chk({tag, "_busy_rdy"}, {31'b0, rdy_a}, 32'h0);
        end
        we = 1'b0;
        chk({tag, "_rdy_edge16"}, 32'(e16), 32'd16);
        chk({tag, "_rdy_edge8"}, 32'(e8), 32'd8);
        // Every register reads back zero, r3 included.
        for (int i = 0; i < 16; i++) begin
            inst = mk(0, i, 15 - i);
            step();
            chk({tag, "_zero_op1"}, op1_a, 32'h0);
            chk({tag, "_zero_op2"}, op2_a, 32'h0);
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            mrdy[k] = 1'b0;
            msince[k] = 0;
            mop1[k] = '0;
            mop2[k] = '0;
        end

        clear_check("clr");

        // Basic read/write.
        wr(5, 32'h1234);
        wr(6, 32'hABCD);
        inst = mk(0, 5, 6);
        step();
        chk("basic_op1", op1_a, 32'h1234);
        chk("basic_op2", op2_a, 32'hABCD);

        // Same-cycle bypass over an old value.
        wr(7, 32'h1);
        inst = mk(0, 7, 0);
        wr(7, 32'h55AA);
        chk("bypass_op1", op1_a, 32'h55AA);

        // Both steering modes together.
        wr(15, 32'h400);
        wr(2, 32'h99);
        inst = mk(2, 9, 10);
        is_ret = 1'b1;
        is_st = 1'b1;
        step();
        chk("steer_op1", op1_a, 32'h400);
        chk("steer_op2", op2_a, 32'h99);
        is_ret = 1'b0;
        is_st = 1'b0;

        // Stall holds outputs while the write still commits.
        inst = mk(0, 5, 6);
        step();
        chk("stall_pre", op1_a, 32'h1234);
        stall = 1'b1;
        wr(5, 32'h7777);
        chk("stall_hold", op1_a, 32'h1234);
        step();
        chk("stall_hold2", op1_a, 32'h1234);
        stall = 1'b0;
        step();
        chk("stall_release", op1_a, 32'h7777);

        // Randomised traffic, including occasional resets.
        for (int c = 0; c < 400; c++) begin
            inst    = $urandom;
            is_st   = 1'($urandom_range(0, 1));
            is_ret  = 1'($urandom_range(0, 1));
            stall   = ($urandom_range(0, 3) == 0);
            we      = 1'($urandom_range(0, 1));
            wr_addr = 4'($urandom_range(0, 15));
            wr_data = $urandom;
            rst     = ($urandom_range(0, 79) == 0);
            step();
        end
        rst = 1'b0;
        is_st = 1'b0;
        is_ret = 1'b0;
        stall = 1'b0;
        we = 1'b0;
        for (int c = 0; c < 20 && !(rdy_a === 1'b1 && rdy_b === 1'b1); c++) step();
        chk("settle_rdy", {31'b0, rdy_a}, 32'h1);

        // Mid-run reset repeats the full clear.
        wr(4, 32'hCAFE);
        clear_check("midrun");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_2r1w.md
# regfile_2r1w

Parametrised SimpleRISC register file for the operand-fetch stage: two registered read ports and one write port. Read addresses come from the instruction word, with the store and return port steering. Writes come from write-back, with same-cycle write-to-read bypass. After reset, a hardware sweep clears every register before `ready` asserts, so the pipeline never reads uninitialised state.

## Interface

Parameters:
- `DATA_W`, 32, register width in bits.
- `NREGS`, 16, register count; power of two, 2..16.
- `ADDR_W`, 4, register index width; must equal log2(`NREGS`).
- `RA_IDX`, `NREGS`-1, index of the return-address register.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `inst`  in  32  fetched instruction; fields `rd`=inst[25:22], `rs1`=inst[21:18], `rs2`=inst[17:14]; each field truncated to its low `ADDR_W` bits.
- `is_st`  in  1  store: port 2 reads `rd` instead of `rs2`.
- `is_ret`  in  1  return: port 1 reads `RA_IDX` instead of `rs1`.
- `stall`  in  1  hold `op1`/`op2` unchanged.
- `we`  in  1  write enable from write-back.
- `wr_addr`  in  `ADDR_W`  write index.
- `wr_data`  in  `DATA_W`  write data.
- `op1`  out  `DATA_W`  registered operand 1.
- `op2`  out  `DATA_W`  registered operand 2.
- `ready`  out  1  high once the clear sweep is done.

## Operation

- Address select: `a1 = is_ret ? RA_IDX : rs1`; `a2 = is_st ? rd : rs2`. `is_st` and `is_ret` are independent; both may be high together.
- FSM has two states:
  - CLEAR is entered on `rst`. A clear counter `cnt` runs 0..`NREGS`-1 and writes zero to `regs[cnt]`, one register per cycle.
  - RUN is entered the cycle after `cnt`=`NREGS`-1 is written. `ready` is registered and goes high on that same edge.
- In CLEAR:
  - `we` is ignored and no write-back occurs.
  - `op1`/`op2` are forced to 0.
  - `stall` has no effect.
- Writes in RUN: when `we`=1, `regs[wr_addr]` ← `wr_data` at the clock edge.
- Reads in RUN when `stall`=0: at the edge, `op1` ← (`we` && `wr_addr`==`a1`) ? `wr_data` : `regs[a1]`. `op2` follows the same rule with `a2`. This bypass means a same-cycle write is visible.
- Reads in RUN when `stall`=1: outputs hold. The write still commits, and no bypass is applied to the held outputs.
- `rst` asserted mid-operation, in any state: it restarts CLEAR and sets `cnt`=0, `ready`=0, `op1`=`op2`=0. Any write presented in that cycle is dropped.
- There is no hardwired zero register. All indices are writable.

## Timing

- Reset values: `op1`=0, `op2`=0, `ready`=0, `cnt`=0, state CLEAR.
- Clear duration: `NREGS` cycles after `rst` deasserts. `ready`=1 at edge `NREGS` counting the first post-reset edge as 1; with 16 registers that is edge 16.
- Read latency: 1 cycle. Operands reflect the inputs at the previous edge.
- Write-to-read: a read of the same index in the same cycle returns the new data (bypass). In the next cycle the data comes from the array.
- Counter wrap: `cnt` saturates in RUN and does not wrap. It is only reloaded by `rst`.

## Test plan

- Reset/clear: assert `rst` 1 cycle, then deassert with `we`=1 writing 0xDEAD to r3 throughout. Required: `ready` rises exactly 16 cycles later; every register reads 0, r3 included.
- Basic read/write: write r5=0x1234 and r6=0xABCD, then read with rs1=5 and rs2=6. Required: next cycle `op1`=0x1234, `op2`=0xABCD.
- Bypass: in a single cycle write r7=0x55AA and read with rs1=7, with the old r7=0x1. Required: `op1`=0x55AA on the next edge.
- Mode steering: set r15=0x400 and rd=2 with r2=0x99, and drive `is_ret`=1 and `is_st`=1 together. Required: `op1`=0x400, `op2`=0x99.
- Stall: with outputs at 0x1234, raise `stall` and write r5=0x7777. Required: `op1` holds 0x1234. After `stall` drops, `op1`=0x7777.
- Mid-run reset and parametrised build: assert `rst` in RUN, then repeat the clear check. Required: `ready`=0 for 16 cycles and all registers 0. Repeat the run with `NREGS`=8 and `ADDR_W`=3, where `ready` rises at edge 8 and `RA_IDX`=7.
